// File: rtl/mem_pkg.sv
// Shared types and helpers for the wait-stated unified memory.
// Used by memory_ws and its wait-state controller.
package mem_pkg;

   typedef enum logic {IDLE, WAIT} wait_state_t;

   localparam int XLEN_DEF = 32;
   localparam int MLEN_DEF = 13;

   function automatic int wait_max(input int rd, input int wr);
      return (rd > wr) ? rd : wr;
   endfunction

   function automatic int cnt_width(input int rd, input int wr);
      return $clog2(wait_max(rd, wr) + 1) + 1;
   endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// Wait-state FSM for the data port: raises halt for a fixed
// number of cycles per access and counts stalled cycles.
module mem_wait_ctrl
   import mem_pkg::*;
#(
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   output logic        halt,
   output logic [31:0] stall_cnt
);

   localparam int CW = cnt_width(RD_WAIT, WR_WAIT);
   localparam logic [CW-1:0] RD_W = CW'(RD_WAIT);
   localparam logic [CW-1:0] WR_W = CW'(WR_WAIT);
   localparam logic [CW-1:0] RW_W = CW'(wait_max(RD_WAIT, WR_WAIT));

   wait_state_t   state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] need;
   logic          req;

   assign req = read | write;

   // wait cycles owed by the request currently presented
   always_comb begin
      need = '0;
      if (read && write) need = RW_W;
      else if (read)     need = RD_W;
      else if (write)    need = WR_W;
   end

   // halt is combinational so the core stalls in the request cycle
   always_comb begin
      halt = 1'b0;
      case (state)
         IDLE:    halt = req && (need != '0);
         WAIT:    halt = req && (cnt < need);
         default: halt = 1'b0;
      endcase
   end

   // state and cycle counter; dropping the request abandons it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && (need != '0)) begin
                  state <= WAIT;
                  cnt   <= CW'(1);
               end
            end
            WAIT: begin
               if (!req || !halt) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // saturating count of stalled cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (halt && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: rtl/memory_ws.sv
// Unified instruction/data memory with registered fetch port,
// byte-writable wait-stated data port and an uncached I/O window.
module memory_ws
   import mem_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int MLEN    = MLEN_DEF,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 0,
   parameter int IO_BIT  = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   insn_addr,
   input  logic [XLEN-1:0]   data_addr,
   input  logic [XLEN-1:0]   data_in,
   input  logic              write,
   input  logic              read,
   input  logic [XLEN/8-1:0] byte_en,
   output logic [XLEN-1:0]   mem_waddr,
   output logic [XLEN-1:0]   insn_data,
   output logic [XLEN-1:0]   data_out,
   output logic              halt,
   output logic [31:0]       stall_cnt
);

   localparam int DEPTH = 2 ** (MLEN - 2);
   localparam int NB    = XLEN / 8;

   if (RD_WAIT < 1) begin : g_bad_rd_wait
      $error("memory_ws: RD_WAIT must be at least 1");
   end
   if (XLEN % 8 != 0) begin : g_bad_xlen
      $error("memory_ws: XLEN must be a multiple of 8");
   end

   logic [XLEN-1:0] mem [DEPTH];
   logic [MLEN-3:0] insn_idx;
   logic [MLEN-3:0] data_idx;
   logic            io;
   logic            commit;
   logic            unused;

   assign insn_idx = insn_addr[MLEN-1:2];
   assign data_idx = data_addr[MLEN-1:2];
   assign io       = data_addr[IO_BIT];
   assign commit   = write & ~halt & ~io;
   assign unused   = ^{insn_addr[XLEN-1:MLEN], insn_addr[1:0]};

   mem_wait_ctrl #(
      .RD_WAIT (RD_WAIT),
      .WR_WAIT (WR_WAIT)
   ) u_wait (
      .clk       (clk),
      .reset     (reset),
      .read      (read),
      .write     (write),
      .halt      (halt),
      .stall_cnt (stall_cnt)
   );

   // registered fetch and data read; reads see pre-write contents
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         insn_data <= '0;
         data_out  <= '0;
         mem_waddr <= '0;
      end else begin
         insn_data <= mem[insn_idx];
         data_out  <= io ? '0 : mem[data_idx];
         mem_waddr <= data_addr;
      end
   end

   // byte-lane write on the edge closing the completion cycle
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_en[i])
               mem[data_idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_memory_ws.sv
// Directed plus random check of memory_ws against a word-array
// model with RD_WAIT=3, WR_WAIT=0, MLEN=13.
module tb_memory_ws;

   localparam int RDW = 3;
   localparam int WRW = 0;

   logic        clk;
   logic        reset;
   logic [31:0] insn_addr;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic        write;
   logic        read;
   logic [3:0]  byte_en;
   logic [31:0] mem_waddr;
   logic [31:0] insn_data;
   logic [31:0] data_out;
   logic        halt;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [2048];
   logic [31:0] sm;

   memory_ws #(
      .XLEN    (32),
      .MLEN    (13),
      .RD_WAIT (RDW),
      .WR_WAIT (WRW),
      .IO_BIT  (31)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .insn_addr (insn_addr),
      .data_addr (data_addr),
      .data_in   (data_in),
      .write     (write),
      .read      (read),
      .byte_en   (byte_en),
      .mem_waddr (mem_waddr),
      .insn_data (insn_data),
      .data_out  (data_out),
      .halt      (halt),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int exp_wait(input logic rd, input logic wr);
      if (rd && wr) return (RDW > WRW) ? RDW : WRW;
      if (rd) return RDW;
      if (wr) return WRW;
      return 0;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[12:2]);
   endfunction

   // one complete access; returns the data seen in the completion cycle
   task automatic access(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] din,
                         input logic [3:0] be, output logic [31:0] dout);
      int  n;
      bit  done;
      logic [31:0] w;
      read      = rd;
      write     = wr;
      data_addr = addr;
      data_in   = din;
      byte_en   = be;
      n    = 0;
      done = 0;
      dout = 'x;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (halt === 1'b0) begin
            done = 1;
            dout = data_out;
         end else begin
            n++;
         end
      end
      if (!done) chk("halt_timeout", 32'(halt), 32'd0);
      chk("halt_cycles", n, exp_wait(rd, wr));
      if (n > 0) chk("mem_waddr", mem_waddr, addr);
      if (rd)
         chk("rdata", dout, addr[31] ? 32'd0 : model[widx(addr)]);
      @(posedge clk);
      #1;
      read  = 1'b0;
      write = 1'b0;
      sm = sm + 32'(n);
      if (wr && !addr[31]) begin
         w = model[widx(addr)];
         for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = din[8*b +: 8];
         model[widx(addr)] = w;
      end
      chk("stall_cnt", stall_cnt, sm);
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
      insn_addr = addr;
      @(posedge clk);
      @(negedge clk);
      chk("insn_data", insn_data, exp);
      chk("fetch_halt", 32'(halt), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] v;
      reset     = 1'b0;
      insn_addr = '0;
      data_addr = '0;
      data_in   = '0;
      write     = 1'b0;
      read      = 1'b0;
      byte_en   = '0;
      sm        = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_insn", insn_data, 32'd0);
      chk("rst_dout", data_out, 32'd0);
      chk("rst_waddr", mem_waddr, 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i <= 16; i++) begin
         v = (i == 5)  ? 32'hDEADBEEF :
             (i == 8)  ? 32'h12345678 :
             (i == 16) ? 32'h11223344 : $urandom;
         access(1'b0, 1'b1, 32'(i * 4), v, 4'hF, d);
      end

      fetch(32'h14, 32'hDEADBEEF);
      fetch(32'h0000_2004, model[1]);

      access(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, d);
      chk("rd_0x20", d, 32'h12345678);

      access(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, d);
      access(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, d);
      chk("byte_lanes", d, 32'h11BB33DD);

      access(1'b0, 1'b1, 32'h8000_0040, 32'hFFFFFFFF, 4'hF, d);
      access(1'b1, 1'b0, 32'h8000_0040, 32'd0, 4'h0, d);
      chk("io_read", d, 32'd0);
      access(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, d);
      chk("io_nowrite", d, 32'h11BB33DD);

      access(1'b1, 1'b0, 32'h0000_2004, 32'd0, 4'h0, d);

      access(1'b1, 1'b1, 32'h24, 32'h5A5A_A5A5, 4'hF, d);
      access(1'b1, 1'b0, 32'h24, 32'd0, 4'h0, d);
      chk("rbw_new", d, 32'h5A5A_A5A5);

      read      = 1'b1;
      write     = 1'b1;
      data_addr = 32'h28;
      data_in   = 32'hCAFEF00D;
      byte_en   = 4'hF;
      @(negedge clk);
      chk("abandon_halt1", 32'(halt), 32'd1);
      @(posedge clk);
      #1;
      read  = 1'b0;
      write = 1'b0;
      @(negedge clk);
      chk("abandon_halt0", 32'(halt), 32'd0);
      sm = sm + 32'd1;
      @(posedge clk);
      #1;
      access(1'b1, 1'b0, 32'h28, 32'd0, 4'h0, d);

      for (int k = 0; k < 40; k++) begin
         a = $urandom;
         a[12:2] = 11'($urandom_range(0, 16));
         a[31] = ($urandom_range(0, 5) == 0);
         v = $urandom;
         case ($urandom_range(0, 2))
            0:       access(1'b1, 1'b0, a, v, 4'($urandom), d);
            1:       access(1'b0, 1'b1, a, v, 4'($urandom), d);
            default: access(1'b1, 1'b1, a, v, 4'($urandom), d);
         endcase
      end

      read      = 1'b1;
      write     = 1'b1;
      data_addr = 32'h2C;
      data_in   = 32'h0BADBEEF;
      byte_en   = 4'hF;
      insn_addr = 32'h14;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_halt", 32'(halt), 32'd1);
      reset = 1'b0;
      write = 1'b0;
      #1;
      chk("mid_rst_halt", 32'(halt), 32'd1);
      chk("mid_rst_insn", insn_data, 32'd0);
      chk("mid_rst_dout", data_out, 32'd0);
      chk("mid_rst_waddr", mem_waddr, 32'd0);
      chk("mid_rst_stall", stall_cnt, 32'd0);
      sm = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      access(1'b1, 1'b0, 32'h2C, 32'd0, 4'h0, d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
